instr_fetch3: RTL and testbench
===============================

Name: instr_fetch3

Overview:
- Fetch stage 3, directly downstream of the fetch2 tag-compare stage.
- Selects the instruction word per fetch: ICache data array read, or bypassed miss-return data.
- Tags each entry with PC, physical address and page-fault status; buffers entries in a small instruction queue.
- Presents the queue head to decode over a valid/ready handshake; backpressures fetch2 via o_stall.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, minimum 2.
- PADDR_W, 34, physical address width (Sv32).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_flush  input  1  synchronous pipeline flush (redirect/exception)
- i_valid  input  1  fetch2 entry valid
- i_pc  input  32  fetch2 PC
- i_paddr  input  PADDR_W  fetch2 physical address
- i_page_fault  input  1  fetch2 page fault
- i_icache_miss  input  1  entry was served by a miss; use miss data
- i_icache_miss_data  input  32  miss-return instruction word
- i_icache_data  input  32  ICache data array read for the current entry
- o_stall  output  1  stall to fetch2: hold entry, do not advance
- o_valid  output  1  queue head valid to decode
- o_instr  output  32  head instruction
- o_pc  output  32  head PC
- o_paddr  output  PADDR_W  head physical address
- o_page_fault  output  1  head carries instruction page fault
- i_ready  input  1  decode accepts head
- i_log_fd  input  32  log file descriptor; 0 disables logging

Behaviour:
- Reset (i_rst_n low, asynchronous): rd_ptr, wr_ptr, count = 0. Outputs: o_valid=0, o_instr=0, o_pc=0, o_paddr=0, o_page_fault=0, o_stall=0. Reset mid-operation discards all entries immediately.
- Word select: i_page_fault=1 -> word 32'h0; else i_icache_miss=1 -> i_icache_miss_data; else -> i_icache_data.
- Push when i_valid & ~o_stall & ~i_flush. Writes {word, i_pc, i_paddr, i_page_fault} at wr_ptr; wr_ptr advances mod DEPTH.
- Pop when o_valid & i_ready & ~i_flush; rd_ptr advances mod DEPTH.
- count: +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
- o_stall = (count == DEPTH), combinational from registered count.
  - When full, no push that cycle even if a pop occurs. The fetch2 entry is held and pushed next cycle.
  - No combinational path from i_ready to o_stall.
- Head outputs are combinational reads at rd_ptr, gated: o_valid = (count != 0). Other head outputs are 0 when empty.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 if the queue was empty. No fall-through bypass.
- i_flush (synchronous): rd_ptr, wr_ptr, count = 0 next cycle. The incoming entry in the flush cycle is dropped; no pop occurs in the flush cycle. i_flush takes priority over push and pop.
- Pointer wrap: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- Page-fault entries flow in order like normal entries; decode raises the exception.
- Logging: when i_log_fd != 0, each push logs "[IF3] Push PC @ %h, Instr: %h, PF: %d" and each pop logs "[IF3] Pop PC @ %h".

Optional Feature:
- Macro: FETCH3_PERF_CNT_EN.
- Defined: adds output ports o_perf_fetched (32) and o_perf_full_cycles (32).
  - o_perf_fetched increments on each push; o_perf_full_cycles increments each cycle o_stall=1.
  - Both reset to 0 on i_rst_n, are not cleared by i_flush, and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Hit path: push PC 0x80000000, i_icache_data=0x00000013, miss=0, ready=1 -> next cycle o_valid=1, o_instr=0x00000013, o_pc=0x80000000; popped that cycle; count returns to 0.
- Miss bypass: i_icache_miss=1, miss_data=0x00500093, i_icache_data=0xDEADBEEF -> head o_instr=0x00500093.
- Page fault: i_page_fault=1, PC 0x00001000 -> head o_page_fault=1, o_instr=0x0, o_pc=0x00001000.
- Full/backpressure: ready=0, push 4 entries (DEPTH=4) -> o_stall=1 with count=4; 5th entry held. Raise ready for one cycle -> pop, no push that cycle; 5th entry pushed next cycle; order PC0..PC4 preserved across pointer wrap.
- Flush: 3 entries queued, i_flush=1 with i_valid=1 and ready=1 -> next cycle o_valid=0, count=0, no pop recorded, incoming entry dropped.
- Async reset mid-stream: i_rst_n low between clock edges with 2 entries queued -> o_valid=0 immediately, all outputs 0; perf counters (if enabled) 0.

Source files
------------

// File: rtl/instr_fetch3.sv
// Fetch stage 3: selects the instruction word, tags it and buffers it in a small queue for decode.
// Optional performance counters are enabled by defining FETCH3_PERF_CNT_EN.
module instr_fetch3 #(
   parameter int DEPTH   = 4,
   parameter int PADDR_W = 34
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               i_valid,
   input  logic [31:0]        i_pc,
   input  logic [PADDR_W-1:0] i_paddr,
   input  logic               i_page_fault,
   input  logic               i_icache_miss,
   input  logic [31:0]        i_icache_miss_data,
   input  logic [31:0]        i_icache_data,
   output logic               o_stall,
   output logic               o_valid,
   output logic [31:0]        o_instr,
   output logic [31:0]        o_pc,
   output logic [PADDR_W-1:0] o_paddr,
   output logic               o_page_fault,
   input  logic               i_ready,
   input  logic [31:0]        i_log_fd
`ifdef FETCH3_PERF_CNT_EN
   ,
   output logic [31:0]        o_perf_fetched,
   output logic [31:0]        o_perf_full_cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   logic [31:0]        mem_instr [DEPTH];
   logic [31:0]        mem_pc    [DEPTH];
   logic [PADDR_W-1:0] mem_paddr [DEPTH];
   logic               mem_pf    [DEPTH];

   logic [31:0]        word;
   logic               push;
   logic               pop;

   // A faulting fetch carries no usable data, so it always enqueues a zero word.
   always_comb begin
      word = i_icache_data;
      if (i_page_fault) begin
         word = 32'h0;
      end else if (i_icache_miss) begin
         word = i_icache_miss_data;
      end
   end

   assign o_stall = (count == CNT_W'(DEPTH));
   assign o_valid = (count != '0);
   assign push    = i_valid & ~o_stall & ~i_flush;
   assign pop     = o_valid & i_ready & ~i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Storage needs no reset: the head outputs are gated by count.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= word;
         mem_pc[wr_ptr]    <= i_pc;
         mem_paddr[wr_ptr] <= i_paddr;
         mem_pf[wr_ptr]    <= i_page_fault;
      end
   end

   always_comb begin
      o_instr      = '0;
      o_pc         = '0;
      o_paddr      = '0;
      o_page_fault = 1'b0;
      if (o_valid) begin
         o_instr      = mem_instr[rd_ptr];
         o_pc         = mem_pc[rd_ptr];
         o_paddr      = mem_paddr[rd_ptr];
         o_page_fault = mem_pf[rd_ptr];
      end
   end

`ifdef FETCH3_PERF_CNT_EN
   // Counters survive flushes so they reflect whole-run activity.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_perf_fetched     <= '0;
         o_perf_full_cycles <= '0;
      end else begin
         if (push) begin
            o_perf_fetched <= o_perf_fetched + 32'd1;
         end
         if (o_stall) begin
            o_perf_full_cycles <= o_perf_full_cycles + 32'd1;
         end
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (i_rst_n && (i_log_fd != 32'd0)) begin
         if (push) begin
            $display("[IF3] Push PC @ %h, Instr: %h, PF: %d", i_pc, word, i_page_fault);
         end
         if (pop) begin
            $display("[IF3] Pop PC @ %h", o_pc);
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch3.sv
// Self-checking bench for instr_fetch3: vector table plus directed multi-cycle sequences.
module tb_instr_fetch3;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        valid;
   logic [31:0] pc;
   logic [33:0] paddr;
   logic        page_fault;
   logic        icache_miss;
   logic [31:0] miss_data;
   logic [31:0] icache_data;
   logic        stall;
   logic        head_valid;
   logic [31:0] head_instr;
   logic [31:0] head_pc;
   logic [33:0] head_paddr;
   logic        head_pf;
   logic        ready;
   logic [31:0] log_fd;
`ifdef FETCH3_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_full_cycles;
`endif

   int checks = 0;
   int errors = 0;

   instr_fetch3 #(.DEPTH(4), .PADDR_W(34)) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_flush            (flush),
      .i_valid            (valid),
      .i_pc               (pc),
      .i_paddr            (paddr),
      .i_page_fault       (page_fault),
      .i_icache_miss      (icache_miss),
      .i_icache_miss_data (miss_data),
      .i_icache_data      (icache_data),
      .o_stall            (stall),
      .o_valid            (head_valid),
      .o_instr            (head_instr),
      .o_pc               (head_pc),
      .o_paddr            (head_paddr),
      .o_page_fault       (head_pf),
      .i_ready            (ready),
      .i_log_fd           (log_fd)
`ifdef FETCH3_PERF_CNT_EN
      ,
      .o_perf_fetched     (perf_fetched),
      .o_perf_full_cycles (perf_full_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [33:0] paddr;
      logic        pf;
      logic        miss;
      logic [31:0] mdata;
      logic [31:0] idata;
      logic        ready;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [33:0] e_paddr;
      logic        e_pf;
      logic        e_stall;
   } vec_t;

   vec_t vecs [6];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkHead(input string tag, input logic v, input logic [31:0] instr,
                            input logic [31:0] hpc, input logic [33:0] hpaddr,
                            input logic hpf, input logic st);
      checkOutput({tag, ".valid"}, 64'(head_valid), 64'(v));
      checkOutput({tag, ".instr"}, 64'(head_instr), 64'(instr));
      checkOutput({tag, ".pc"}, 64'(head_pc), 64'(hpc));
      checkOutput({tag, ".paddr"}, 64'(head_paddr), 64'(hpaddr));
      checkOutput({tag, ".pf"}, 64'(head_pf), 64'(hpf));
      checkOutput({tag, ".stall"}, 64'(stall), 64'(st));
   endtask

   // Drive one cycle of fetch2/decode inputs, clock it, then settle for sampling.
   task automatic applyStimulus(input logic v, input logic [31:0] p, input logic pf,
                                input logic m, input logic [31:0] md, input logic [31:0] id,
                                input logic r, input logic f);
      valid       = v;
      pc          = p;
      paddr       = {2'b01, p};
      page_fault  = pf;
      icache_miss = m;
      miss_data   = md;
      icache_data = id;
      ready       = r;
      flush       = f;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pcOf(input int i);
      return 32'h8000_1000 + 32'(4 * i);
   endfunction

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      valid = 1'b0;
      pc = '0;
      paddr = '0;
      page_fault = 1'b0;
      icache_miss = 1'b0;
      miss_data = '0;
      icache_data = '0;
      ready = 1'b0;
      log_fd = 32'd0;

      vecs[0] = '{1'b1, 32'h8000_0000, 34'h1_8000_0000, 1'b0, 1'b0, 32'h0, 32'h0000_0013, 1'b1,
                  1'b1, 32'h0000_0013, 32'h8000_0000, 34'h1_8000_0000, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 32'h0, 34'h1_0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                  1'b0, 32'h0, 32'h0, 34'h0, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h8000_0004, 34'h1_8000_0004, 1'b0, 1'b1, 32'h0050_0093, 32'hDEAD_BEEF, 1'b0,
                  1'b1, 32'h0050_0093, 32'h8000_0004, 34'h1_8000_0004, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_1000, 34'h1_0000_1000, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 1'b1,
                  1'b1, 32'h0, 32'h0000_1000, 34'h1_0000_1000, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 32'h0000_2000, 34'h1_0000_2000, 1'b1, 1'b1, 32'h0000_AAAA, 32'h5555_0000, 1'b1,
                  1'b1, 32'h0, 32'h0000_2000, 34'h1_0000_2000, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 32'h0, 34'h1_0000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                  1'b0, 32'h0, 32'h0, 34'h0, 1'b0, 1'b0};

      #12;
      checkHead("reset", 1'b0, 32'h0, 32'h0, 34'h0, 1'b0, 1'b0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].pc, vecs[i].pf, vecs[i].miss, vecs[i].mdata,
                       vecs[i].idata, vecs[i].ready, 1'b0);
         checkHead($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc,
                   vecs[i].e_paddr, vecs[i].e_pf, vecs[i].e_stall);
      end

      // Fill to capacity with decode stalled; the fifth entry must wait.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pcOf(i), 1'b0, 1'b0, 32'h0, 32'h100 + 32'(i), 1'b0, 1'b0);
         checkOutput($sformatf("fill%0d.stall", i), 64'(stall), 64'(i == 3));
         checkOutput($sformatf("fill%0d.pc", i), 64'(head_pc), 64'(pcOf(0)));
      end
      applyStimulus(1'b1, pcOf(4), 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, 1'b0);
      checkOutput("held.stall", 64'(stall), 64'd1);
      checkOutput("held.pc", 64'(head_pc), 64'(pcOf(0)));
      applyStimulus(1'b1, pcOf(4), 1'b0, 1'b0, 32'h0, 32'h104, 1'b1, 1'b0);
      checkOutput("popfull.stall", 64'(stall), 64'd0);
      checkOutput("popfull.pc", 64'(head_pc), 64'(pcOf(1)));
      applyStimulus(1'b1, pcOf(4), 1'b0, 1'b0, 32'h0, 32'h104, 1'b0, 1'b0);
      checkOutput("refill.stall", 64'(stall), 64'd1);
      for (int i = 1; i <= 4; i++) begin
         checkOutput($sformatf("drain%0d.pc", i), 64'(head_pc), 64'(pcOf(i)));
         checkOutput($sformatf("drain%0d.instr", i), 64'(head_instr), 64'(32'h100 + 32'(i)));
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      checkOutput("drained.valid", 64'(head_valid), 64'd0);

      // Flush with three queued entries and a live incoming entry.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h9000_0000 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h200, 1'b0, 1'b0);
      end
      checkOutput("preflush.pc", 64'(head_pc), 64'h9000_0000);
      applyStimulus(1'b1, 32'h9000_0100, 1'b0, 1'b0, 32'h0, 32'h300, 1'b1, 1'b1);
      checkHead("flush", 1'b0, 32'h0, 32'h0, 34'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("postflush.valid", 64'(head_valid), 64'd0);
      applyStimulus(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0, 32'h33, 1'b0, 1'b0);
      checkHead("afterflush", 1'b1, 32'h33, 32'hA000_0000, 34'h1_A000_0000, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Flushing a full queue must release the stall.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, pcOf(i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
      checkOutput("fullflush.pre", 64'(stall), 64'd1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("fullflush.stall", 64'(stall), 64'd0);
      checkOutput("fullflush.valid", 64'(head_valid), 64'd0);

      // Asynchronous reset between edges with two entries queued.
      applyStimulus(1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'h0, 32'h77, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hB000_0004, 1'b0, 1'b0, 32'h0, 32'h78, 1'b0, 1'b0);
      valid = 1'b0;
      checkOutput("prereset.valid", 64'(head_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkHead("asyncreset", 1'b0, 32'h0, 32'h0, 34'h0, 1'b0, 1'b0);
`ifdef FETCH3_PERF_CNT_EN
      checkOutput("asyncreset.perf_fetched", 64'(perf_fetched), 64'd0);
      checkOutput("asyncreset.perf_full", 64'(perf_full_cycles), 64'd0);
`endif
      #3;
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("postreset.valid", 64'(head_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
